// File: rtl/module_evento_boton_pkg.sv
// pkg_boton: shared FSM state type and press-count width for the button event decoder
package pkg_boton;
  typedef enum logic [1:0] {IDLE, PRESSED, HOLD} estado_boton_t;
  localparam int PRESS_CNT_W = 8;
endpackage

// File: rtl/module_evento_boton_contador.sv
// module_contador_hold: hold counter (clk_i, reset_ni, clr_i, en_i, sel_long_i -> cnt_o, tc_o at LONG-1 or REPEAT-1)
module module_contador_hold
  import pkg_boton::*;
#(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sel_long_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  always_comb begin
    cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    lim   = sel_long_i ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == lim;
endmodule

// File: rtl/module_evento_boton.sv
// module_evento_boton: debounced level -> press/release/long/repeat pulses, held flag, wrapping press count
module module_evento_boton
  import pkg_boton::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   btn_db_i,
  output logic                   press_o,
  output logic                   release_o,
  output logic                   long_press_o,
  output logic                   repeat_o,
  output logic                   held_o,
  output logic [PRESS_CNT_W-1:0] press_count_o
);
  localparam int CNT_W = $clog2(LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES);
  estado_boton_t          state_q;
  logic                   press_q, release_q, long_q, repeat_q, held_q, tc;
  logic [PRESS_CNT_W-1:0] count_q;
  logic [CNT_W-1:0]       cnt;
  module_contador_hold #(
    .LONG_CYCLES  (LONG_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_cnt (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clr_i     (state_q == IDLE || !btn_db_i || tc),
    .en_i      (state_q != IDLE),
    .sel_long_i(state_q == PRESSED),
    .cnt_o     (cnt),
    .tc_o      (tc)
  );
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q   <= IDLE;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (btn_db_i) begin
            state_q <= PRESSED;
            held_q  <= 1'b1;
            press_q <= 1'b1;
            count_q <= count_q + 1'b1;
          end
        PRESSED:
          if (!btn_db_i) begin
            state_q   <= IDLE;
            held_q    <= 1'b0;
            release_q <= 1'b1;
          end else if (tc) begin
            state_q <= HOLD;
            long_q  <= 1'b1;
          end
        HOLD:
          if (!btn_db_i) begin
            state_q   <= IDLE;
            held_q    <= 1'b0;
            release_q <= 1'b1;
          end else if (tc) repeat_q <= 1'b1;
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
        end
      endcase
    end
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_q;
  assign repeat_o      = repeat_q;
  assign held_o        = held_q;
  assign press_count_o = count_q;
endmodule

// File: tb/tb_module_evento_boton.sv
// tb_module_evento_boton: directed checks of press/release/long/repeat/held/count with LONG=8, REPEAT=4
module tb_module_evento_boton;
  logic       clk = 1'b0;
  logic       reset_ni, btn;
  logic       press, rel, lng, rep, held;
  logic [7:0] count;
  int         total = 0, passed = 0;
  module_evento_boton #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .btn_db_i     (btn),
    .press_o      (press),
    .release_o    (rel),
    .long_press_o (lng),
    .repeat_o     (rep),
    .held_o       (held),
    .press_count_o(count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset_ni = 1'b0;
    btn = 1'b0;
    #2;
    total++;
    if ({press, rel, lng, rep, held} !== 5'b0) $display("FAIL reset_outs got %b want 00000", {press, rel, lng, rep, held});
    else passed++;
    total++;
    if (count !== 8'd0) $display("FAIL reset_count got %0d want 0", count);
    else passed++;
    step();
    reset_ni = 1'b1;
    step();
    total++;
    if ({press, rel, lng, rep, held} !== 5'b0) $display("FAIL idle_outs got %b want 00000", {press, rel, lng, rep, held});
    else passed++;
  endtask
  task automatic test_short();
    logic [4:0] exp;
    for (int e = 0; e <= 4; e++) begin
      btn = e < 3;
      step();
      exp = {e == 0, e == 3, 1'b0, 1'b0, e < 3};
      total++;
      if ({press, rel, lng, rep, held} !== exp) $display("FAIL short_e%0d got %b want %b", e, {press, rel, lng, rep, held}, exp);
      else passed++;
    end
    total++;
    if (count !== 8'd1) $display("FAIL short_count got %0d want 1", count);
    else passed++;
  endtask
  task automatic test_long();
    logic [4:0] exp;
    for (int e = 0; e <= 22; e++) begin
      btn = e < 21;
      step();
      exp = {e == 0, e == 21, e == 8, e > 8 && e < 21 && (e - 8) % 4 == 0, e < 21};
      total++;
      if ({press, rel, lng, rep, held} !== exp) $display("FAIL long_e%0d got %b want %b", e, {press, rel, lng, rep, held}, exp);
      else passed++;
    end
    total++;
    if (count !== 8'd2) $display("FAIL long_count got %0d want 2", count);
    else passed++;
  endtask
  task automatic test_collision();
    logic [4:0] exp;
    for (int e = 0; e <= 10; e++) begin
      btn = e < 8;
      step();
      exp = {e == 0, e == 8, 1'b0, 1'b0, e < 8};
      total++;
      if ({press, rel, lng, rep, held} !== exp) $display("FAIL collide_e%0d got %b want %b", e, {press, rel, lng, rep, held}, exp);
      else passed++;
    end
  endtask
  task automatic test_wrap();
    #3 reset_ni = 1'b0;
    #1 reset_ni = 1'b1;
    for (int p = 1; p <= 257; p++) begin
      btn = 1'b1;
      step();
      if (p == 255) begin
        total++;
        if (count !== 8'd255) $display("FAIL wrap_255 got %0d want 255", count);
        else passed++;
      end
      if (p == 256) begin
        total++;
        if (count !== 8'd0) $display("FAIL wrap_256 got %0d want 0", count);
        else passed++;
      end
      btn = 1'b0;
      step();
    end
    total++;
    if (count !== 8'd1) $display("FAIL wrap_257 got %0d want 1", count);
    else passed++;
  endtask
  task automatic test_async_reset();
    btn = 1'b1;
    for (int e = 0; e <= 10; e++) step();
    total++;
    if (held !== 1'b1) $display("FAIL hold_before_reset got %b want 1", held);
    else passed++;
    #2 reset_ni = 1'b0;
    #1;
    total++;
    if ({press, rel, lng, rep, held, count} !== 13'b0) $display("FAIL async_reset got %b want 0", {press, rel, lng, rep, held, count});
    else passed++;
    step();
    total++;
    if ({press, rel, lng, rep, held, count} !== 13'b0) $display("FAIL reset_hold_edge got %b want 0", {press, rel, lng, rep, held, count});
    else passed++;
    #2 reset_ni = 1'b1;
    step();
    total++;
    if ({press, rel, lng, rep, held} !== 5'b10001) $display("FAIL post_reset_press got %b want 10001", {press, rel, lng, rep, held});
    else passed++;
    total++;
    if (count !== 8'd1) $display("FAIL post_reset_count got %0d want 1", count);
    else passed++;
    btn = 1'b0;
    step();
    total++;
    if ({press, rel, lng, rep, held} !== 5'b01000) $display("FAIL post_reset_release got %b want 01000", {press, rel, lng, rep, held});
    else passed++;
  endtask
  task automatic test_glitch();
    logic [4:0] exp;
    for (int e = 0; e <= 3; e++) begin
      btn = e == 0;
      step();
      exp = {e == 0, e == 1, 1'b0, 1'b0, e == 0};
      total++;
      if ({press, rel, lng, rep, held} !== exp) $display("FAIL glitch_e%0d got %b want %b", e, {press, rel, lng, rep, held}, exp);
      else passed++;
      total++;
      if ($countones({press, rel, lng, rep}) > 1) $display("FAIL glitch_onehot_e%0d got %b want at most one pulse", e, {press, rel, lng, rep});
      else passed++;
    end
    total++;
    if (count !== 8'd2) $display("FAIL glitch_count got %0d want 2", count);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_short();
    test_long();
    test_collision();
    test_wrap();
    test_async_reset();
    test_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
